// File: rtl/control_pipeline_pkg.sv
// Shared pipeline control definitions: bundle layouts, forward selects, opcode groups.
// No logic; imported by the control pipeline and the control decoder.
// Bundle bit positions here must match the packed struct field order below.
package control_pipeline_pkg;

    localparam int EX_W  = 3;
    localparam int M_W   = 3;
    localparam int WB_W  = 2;
    localparam int REG_W = 5;

    localparam int EX_ALU_SRC    = 0;
    localparam int EX_ALU_OP_LO  = 1;
    localparam int EX_ALU_OP_HI  = 2;
    localparam int M_MEM_READ    = 0;
    localparam int M_MEM_WRITE   = 1;
    localparam int M_BRANCH      = 2;
    localparam int WB_REG_WRITE  = 0;
    localparam int WB_MEM_TO_REG = 1;

    typedef logic [1:0] fwd_sel_t;
    localparam fwd_sel_t FWD_REG   = 2'b00;
    localparam fwd_sel_t FWD_MEMWB = 2'b01;
    localparam fwd_sel_t FWD_EXMEM = 2'b10;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src;
    } ex_t;

    typedef struct packed {
        logic branch;
        logic mem_write;
        logic mem_read;
    } m_t;

    typedef struct packed {
        logic mem_to_reg;
        logic reg_write;
    } wb_t;

    typedef struct packed {
        ex_t              ex;
        m_t               m;
        wb_t              wb;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
    } idex_t;

    typedef struct packed {
        m_t               m;
        wb_t              wb;
        logic [REG_W-1:0] rd;
    } exmem_t;

    typedef struct packed {
        wb_t              wb;
        logic [REG_W-1:0] rd;
    } memwb_t;

    // x0 is hardwired zero, so a write to it never produces a usable value.
    function automatic logic reg_hit(input logic wr, input logic [REG_W-1:0] rd,
                                     input logic [REG_W-1:0] rs);
        return wr && (rd != '0) && (rd == rs);
    endfunction

endpackage

// File: rtl/control_pipeline_forwarding.sv
// ALU operand forwarding select; EX/MEM result wins over MEM/WB result.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of the stage registers.
module forwarding_unit
    import control_pipeline_pkg::*;
(
    input  logic             exmem_reg_write,
    input  logic [REG_W-1:0] exmem_rd,
    input  logic             memwb_reg_write,
    input  logic [REG_W-1:0] memwb_rd,
    input  logic [REG_W-1:0] idex_rs1,
    input  logic [REG_W-1:0] idex_rs2,
    output logic [1:0]       forward_a,
    output logic [1:0]       forward_b
);

    function automatic fwd_sel_t select(input logic [REG_W-1:0] rs);
        if (reg_hit(exmem_reg_write, exmem_rd, rs))
            return FWD_EXMEM;
        else if (reg_hit(memwb_reg_write, memwb_rd, rs))
            return FWD_MEMWB;
        else
            return FWD_REG;
    endfunction

    assign forward_a = select(idex_rs1);
    assign forward_b = select(idex_rs2);

endmodule

// File: rtl/control_pipeline.sv
// Control-bundle pipeline ID/EX -> EX/MEM -> MEM/WB with load-use stall, branch flush, forwarding.
// Latency: EX bits at +1, M bits at +2, WB bits at +3 cycles; hazard outputs combinational.
// Backpressure: stall holds IF/ID and injects a bubble; flush squashes ID/EX and EX/MEM.
module control_pipeline
    import control_pipeline_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [EX_W-1:0]  ex_in,
    input  logic [M_W-1:0]   m_in,
    input  logic [WB_W-1:0]  wb_in,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic [REG_W-1:0] id_rd,
    input  logic             mem_zero,
    output logic [1:0]       alu_op,
    output logic             alu_src,
    output logic             mem_branch,
    output logic             mem_write,
    output logic             mem_read,
    output logic             wb_mem_to_reg,
    output logic             wb_reg_write,
    output logic [REG_W-1:0] wb_rd,
    output logic [1:0]       forward_a,
    output logic [1:0]       forward_b,
    output logic             stall,
    output logic             flush,
    output logic [7:0]       bubble_count
);

    idex_t      idex_q;
    idex_t      idex_d;
    exmem_t     exmem_q;
    memwb_t     memwb_q;
    logic [7:0] bubble_q;
    logic       load_use;

    assign flush    = exmem_q.m.branch & mem_zero;
    assign load_use = idex_q.m.mem_read && (idex_q.rd != '0) && id_valid &&
                      ((idex_q.rd == id_rs1) || (idex_q.rd == id_rs2));
    assign stall    = load_use & ~flush;

    // Bubbles, stalls and squashed slots all enter ID/EX as an all-zero entry.
    always_comb begin
        idex_d = '0;
        if (id_valid && !stall && !flush) begin
            idex_d = '{ex: ex_t'(ex_in), m: m_t'(m_in), wb: wb_t'(wb_in),
                       rs1: id_rs1, rs2: id_rs2, rd: id_rd};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
        end else begin
            idex_q  <= idex_d;
            exmem_q <= flush ? '0 : '{m: idex_q.m, wb: idex_q.wb, rd: idex_q.rd};
            memwb_q <= '{wb: exmem_q.wb, rd: exmem_q.rd};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bubble_q <= '0;
        else if (stall && (bubble_q != 8'hFF))
            bubble_q <= bubble_q + 8'd1;
    end

    forwarding_unit u_forwarding_unit (
        .exmem_reg_write (exmem_q.wb.reg_write),
        .exmem_rd        (exmem_q.rd),
        .memwb_reg_write (memwb_q.wb.reg_write),
        .memwb_rd        (memwb_q.rd),
        .idex_rs1        (idex_q.rs1),
        .idex_rs2        (idex_q.rs2),
        .forward_a       (forward_a),
        .forward_b       (forward_b)
    );

    assign alu_op        = idex_q.ex.alu_op;
    assign alu_src       = idex_q.ex.alu_src;
    assign mem_branch    = exmem_q.m.branch;
    assign mem_write     = exmem_q.m.mem_write;
    assign mem_read      = exmem_q.m.mem_read;
    assign wb_mem_to_reg = memwb_q.wb.mem_to_reg;
    assign wb_reg_write  = memwb_q.wb.reg_write;
    assign wb_rd         = memwb_q.rd;
    assign bubble_count  = bubble_q;

endmodule

// File: tb/tb_control_pipeline.sv
// Bench for control_pipeline: age-indexed instruction history model plus directed literal checks.
module tb_control_pipeline;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [2:0] ex_in;
    logic [2:0] m_in;
    logic [1:0] wb_in;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       mem_zero;
    logic [1:0] alu_op;
    logic       alu_src;
    logic       mem_branch, mem_write, mem_read;
    logic       wb_mem_to_reg, wb_reg_write;
    logic [4:0] wb_rd;
    logic [1:0] forward_a, forward_b;
    logic       stall, flush;
    logic [7:0] bubble_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    control_pipeline dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .ex_in(ex_in), .m_in(m_in), .wb_in(wb_in),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .mem_zero(mem_zero),
        .alu_op(alu_op), .alu_src(alu_src),
        .mem_branch(mem_branch), .mem_write(mem_write), .mem_read(mem_read),
        .wb_mem_to_reg(wb_mem_to_reg), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
        .forward_a(forward_a), .forward_b(forward_b),
        .stall(stall), .flush(flush), .bubble_count(bubble_count)
    );

    logic [26:0] all_outs;
    assign all_outs = {alu_op, alu_src, mem_branch, mem_write, mem_read, wb_mem_to_reg,
                       wb_reg_write, wb_rd, forward_a, forward_b, stall, flush, bubble_count};

    // Instruction record: ex={op[1:0],src}, m={br,mw,mr}, wb={m2r,rw}.
    typedef struct packed {
        logic [2:0] ex;
        logic [2:0] m;
        logic [1:0] wb;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
    } ins_t;

    // age[0]: issued last cycle (EX), age[1]: two cycles ago (MEM), age[2]: three (WB).
    ins_t age [3];
    int   cnt;
    logic e_flush, e_stall;
    logic [1:0] e_fa, e_fb;
    ins_t cur;

    function automatic logic [1:0] src_for(input logic [4:0] rs, input ins_t older, input ins_t oldest);
        if (rs == 5'd0) return 2'd0;
        if (older.wb[0] && older.rd == rs) return 2'd2;
        if (oldest.wb[0] && oldest.rd == rs) return 2'd1;
        return 2'd0;
    endfunction

    always_comb begin
        cur     = '{ex: ex_in, m: m_in, wb: wb_in, rs1: id_rs1, rs2: id_rs2, rd: id_rd};
        e_flush = age[1].m[2] && mem_zero;
        e_stall = !e_flush && id_valid && age[0].m[0] && age[0].rd != 5'd0 &&
                  (id_rs1 == age[0].rd || id_rs2 == age[0].rd);
        e_fa    = src_for(age[0].rs1, age[1], age[2]);
        e_fb    = src_for(age[0].rs2, age[1], age[2]);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age[0] <= '0;
            age[1] <= '0;
            age[2] <= '0;
            cnt    <= 0;
        end else begin
            age[2] <= age[1];
            age[1] <= e_flush ? ins_t'(0) : age[0];
            age[0] <= (e_flush || e_stall || !id_valid) ? ins_t'(0) : cur;
            cnt    <= e_stall ? ((cnt + 1 > 255) ? 255 : cnt + 1) : cnt;
        end
    end

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        cmp("alu_op",        32'(alu_op),        32'(age[0].ex[2:1]));
        cmp("alu_src",       32'(alu_src),       32'(age[0].ex[0]));
        cmp("mem_branch",    32'(mem_branch),    32'(age[1].m[2]));
        cmp("mem_write",     32'(mem_write),     32'(age[1].m[1]));
        cmp("mem_read",      32'(mem_read),      32'(age[1].m[0]));
        cmp("wb_mem_to_reg", 32'(wb_mem_to_reg), 32'(age[2].wb[1]));
        cmp("wb_reg_write",  32'(wb_reg_write),  32'(age[2].wb[0]));
        cmp("wb_rd",         32'(wb_rd),         32'(age[2].rd));
        cmp("forward_a",     32'(forward_a),     32'(e_fa));
        cmp("forward_b",     32'(forward_b),     32'(e_fb));
        cmp("stall",         32'(stall),         32'(e_stall));
        cmp("flush",         32'(flush),         32'(e_flush));
        cmp("bubble_count",  32'(bubble_count),  32'(cnt));
    end

    task automatic drv(input logic v, input logic [2:0] ex, input logic [2:0] m, input logic [1:0] wb,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        id_valid = v; ex_in = ex; m_in = m; wb_in = wb;
        id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    endtask

    task automatic bub();
        drv(1'b0, 3'b111, 3'b111, 2'b11, 5'd7, 5'd7, 5'd6);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        mem_zero = 1'b0;
        drv(1'b0, 3'd0, 3'd0, 2'd0, 5'd0, 5'd0, 5'd0);
        neg(); neg();
        cmp("reset_outputs", 32'(all_outs), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Pass-through of one bundle to EX, then WB.
        drv(1'b1, 3'b101, 3'b000, 2'b01, 5'd1, 5'd2, 5'd5);
        tick(); bub(); neg();
        cmp("pt_alu_op", 32'(alu_op), 32'd2);
        cmp("pt_alu_src", 32'(alu_src), 32'd1);
        tick(); tick(); neg();
        cmp("pt_wb_reg_write", 32'(wb_reg_write), 32'd1);
        cmp("pt_wb_rd", 32'(wb_rd), 32'd5);

        // Load-use: ld x7 then reader of x7.
        tick(); drv(1'b1, 3'b001, 3'b001, 2'b11, 5'd2, 5'd0, 5'd7);
        tick(); drv(1'b1, 3'b100, 3'b000, 2'b01, 5'd7, 5'd8, 5'd9); neg();
        cmp("lu_stall", 32'(stall), 32'd1);
        cmp("lu_count_before", 32'(bubble_count), 32'd0);
        tick(); neg();
        cmp("lu_stall_once", 32'(stall), 32'd0);
        cmp("lu_bubble_alu_op", 32'(alu_op), 32'd0);
        cmp("lu_bubble_count", 32'(bubble_count), 32'd1);
        cmp("lu_ld_in_mem", 32'(mem_read), 32'd1);
        tick(); bub(); neg();
        cmp("lu_user_alu_op", 32'(alu_op), 32'd2);
        cmp("lu_fwd_memwb", 32'(forward_a), 32'd1);

        // Two writers of x3, then reader of x3: newer (EX/MEM) wins.
        tick(); drv(1'b1, 3'b100, 3'b000, 2'b01, 5'd0, 5'd0, 5'd3);
        tick(); drv(1'b1, 3'b100, 3'b000, 2'b01, 5'd0, 5'd0, 5'd3);
        tick(); drv(1'b1, 3'b100, 3'b000, 2'b01, 5'd3, 5'd0, 5'd9);
        tick(); bub(); neg();
        cmp("fwd_a_exmem", 32'(forward_a), 32'd2);
        cmp("fwd_b_none", 32'(forward_b), 32'd0);
        tick(); drv(1'b1, 3'b100, 3'b000, 2'b01, 5'd0, 5'd0, 5'd4);
        tick(); bub();
        tick(); drv(1'b1, 3'b100, 3'b000, 2'b01, 5'd0, 5'd4, 5'd0);
        tick(); bub(); neg();
        cmp("fwd_b_memwb", 32'(forward_b), 32'd1);
        tick(); drv(1'b1, 3'b100, 3'b000, 2'b01, 5'd9, 5'd9, 5'd0);
        tick(); drv(1'b1, 3'b100, 3'b000, 2'b01, 5'd0, 5'd0, 5'd1);
        tick(); bub(); neg();
        cmp("fwd_a_x0", 32'(forward_a), 32'd0);
        cmp("fwd_b_x0", 32'(forward_b), 32'd0);

        // Taken branch squashes the two younger instructions.
        tick(); drv(1'b1, 3'b010, 3'b100, 2'b00, 5'd1, 5'd2, 5'd0);
        tick(); drv(1'b1, 3'b100, 3'b000, 2'b01, 5'd11, 5'd12, 5'd10);
        tick(); drv(1'b1, 3'b100, 3'b000, 2'b01, 5'd14, 5'd15, 5'd13); mem_zero = 1'b1; neg();
        cmp("br_flush", 32'(flush), 32'd1);
        cmp("br_mem_branch", 32'(mem_branch), 32'd1);
        tick(); mem_zero = 1'b0; bub(); neg();
        cmp("br_idex_zero", 32'({alu_op, alu_src}), 32'd0);
        cmp("br_exmem_zero", 32'({mem_branch, mem_write, mem_read}), 32'd0);
        cmp("br_wb_branch", 32'(wb_reg_write), 32'd0);
        tick(); neg();
        cmp("br_killed_wb", 32'({wb_reg_write, wb_rd}), 32'd0);

        // Untaken branch: younger instruction survives.
        tick(); drv(1'b1, 3'b010, 3'b100, 2'b00, 5'd1, 5'd2, 5'd0);
        tick(); drv(1'b1, 3'b100, 3'b000, 2'b01, 5'd11, 5'd12, 5'd10);
        tick(); bub(); neg();
        cmp("nbr_flush", 32'(flush), 32'd0);
        tick(); tick(); neg();
        cmp("nbr_wb_reg_write", 32'(wb_reg_write), 32'd1);
        cmp("nbr_wb_rd", 32'(wb_rd), 32'd10);

        // Load-use coincident with taken branch: flush wins, no bubble counted.
        tick(); drv(1'b1, 3'b010, 3'b100, 2'b00, 5'd1, 5'd2, 5'd0);
        tick(); drv(1'b1, 3'b001, 3'b001, 2'b11, 5'd2, 5'd0, 5'd7);
        tick(); drv(1'b1, 3'b100, 3'b000, 2'b01, 5'd7, 5'd0, 5'd9); mem_zero = 1'b1; neg();
        cmp("sim_flush", 32'(flush), 32'd1);
        cmp("sim_stall", 32'(stall), 32'd0);
        tick(); mem_zero = 1'b0; bub(); neg();
        cmp("sim_count", 32'(bubble_count), 32'd1);

        // Repeated load-use stalls drive the counter into saturation.
        tick(); drv(1'b1, 3'b001, 3'b001, 2'b11, 5'd7, 5'd0, 5'd7);
        repeat (620) tick();
        bub(); neg();
        cmp("sat_count", 32'(bubble_count), 32'd255);

        // Fill the pipeline, then assert reset between edges.
        tick(); drv(1'b1, 3'b101, 3'b011, 2'b11, 5'd1, 5'd2, 5'd3);
        tick(); drv(1'b1, 3'b010, 3'b100, 2'b10, 5'd3, 5'd3, 5'd4);
        tick(); drv(1'b1, 3'b100, 3'b001, 2'b11, 5'd4, 5'd5, 5'd6);
        tick();
        #2 rst_n = 1'b0;
        #1;
        cmp("async_reset_outputs", 32'(all_outs), 32'd0);
        neg();
        #2 rst_n = 1'b1;
        drv(1'b1, 3'b101, 3'b000, 2'b01, 5'd1, 5'd2, 5'd5);
        tick(); bub(); neg();
        cmp("post_reset_capture", 32'({alu_op, alu_src}), 32'd5);

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
